i2c_slave_apb_ctrl: RTL and testbench

APB3 control and buffering front-end for the I2C slave core. Holds the core's enable and 7-bit own address, feeds transmit bytes to the core from a TX FIFO, and collects received bytes into an RX FIFO. Raises a maskable interrupt on byte events and error conditions. Sits between the APB bus and the slave FSM/shift-register datapath, in the same `pclk` domain.

---
 rtl/i2c_slave_apb_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_slave_apb_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_apb_ctrl.sv
// APB3 control/buffer front-end for the I2C slave core: CTRL/ADDR registers, TX and RX byte FIFOs, interrupt flags.
// Build option I2CS_IRQ_EN: when defined INT_STAT/INT_EN/irq are live; otherwise they read 0 and irq stays 0.
module i2c_slave_apb_ctrl #(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [6:0] DEFAULT_ADDR = 7'h50
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq,
  output logic        core_en,
  output logic [6:0]  own_addr,
  output logic [7:0]  tx_byte,
  input  logic        tx_load,
  input  logic [7:0]  rx_byte,
  input  logic        rx_load,
  input  logic [2:0]  core_state
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef I2CS_IRQ_EN
  localparam logic IRQ_IMPL = 1'b1;
`else
  localparam logic IRQ_IMPL = 1'b0;
`endif

  localparam logic [2:0] R_CTRL     = 3'd0;
  localparam logic [2:0] R_ADDR     = 3'd1;
  localparam logic [2:0] R_STATUS   = 3'd2;
  localparam logic [2:0] R_TXDATA   = 3'd3;
  localparam logic [2:0] R_RXDATA   = 3'd4;
  localparam logic [2:0] R_INT_STAT = 3'd5;
  localparam logic [2:0] R_INT_EN   = 3'd6;

  logic          en_q, en_d;
  logic [6:0]    addr_q, addr_d;
  logic [3:0]    int_stat_q, int_stat_d, int_en_q, int_en_d;
  logic          irq_q, irq_d;
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    tx_mem_d [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_d [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic       apb_wr, apb_rd;
  logic [2:0] reg_sel;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_flush, rx_flush, tx_push, tx_pop, rx_push, rx_pop;
  logic       rx_done, tx_req, rx_ovr, tx_und;
  logic [3:0] int_set, int_clr;
  logic [31:0] status;
  logic       unused_ok;

  assign apb_wr  = psel & penable & pwrite;
  assign apb_rd  = psel & penable & ~pwrite;
  assign reg_sel = paddr[4:2];

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));

  assign tx_flush = apb_wr & (reg_sel == R_CTRL) & pwdata[2];
  assign rx_flush = apb_wr & (reg_sel == R_CTRL) & pwdata[1];
  assign tx_push  = apb_wr & (reg_sel == R_TXDATA) & ~tx_full;
  assign tx_pop   = tx_load & ~tx_empty;
  assign rx_pop   = apb_rd & (reg_sel == R_RXDATA) & ~rx_empty;
  // A same-cycle pop frees a slot, so a full RX FIFO can still accept the core byte.
  assign rx_push  = rx_load & (~rx_full | rx_pop);

  // A colliding flush discards the core event and suppresses its flag.
  assign rx_done = rx_push & ~rx_flush;
  assign tx_req  = tx_pop & ~tx_flush;
  assign rx_ovr  = rx_load & ~rx_push & ~rx_flush;
  assign tx_und  = tx_load & tx_empty & ~tx_flush;
  assign int_set = {tx_und, rx_ovr, tx_req, rx_done};
  assign int_clr = (apb_wr && reg_sel == R_INT_STAT) ? pwdata[3:0] : 4'h0;

  assign status = {11'b0, 5'(rx_cnt_q), 3'b0, 5'(tx_cnt_q), core_state,
                   (core_state != 3'b000), rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    prdata  = 32'h0;
    pslverr = 1'b0;
    if (apb_rd) begin
      case (reg_sel)
        R_CTRL:     prdata = {31'b0, en_q};
        R_ADDR:     prdata = {25'b0, addr_q};
        R_STATUS:   prdata = status;
        R_RXDATA: begin
          if (rx_empty) pslverr = 1'b1;
          else          prdata  = {24'b0, rx_mem_q[rx_rd_q]};
        end
        R_INT_STAT: prdata = {28'b0, int_stat_q};
        R_INT_EN:   prdata = {28'b0, int_en_q};
        default:    prdata = 32'h0;
      endcase
    end else if (apb_wr && reg_sel == R_TXDATA && tx_full) begin
      pslverr = 1'b1;
    end
  end

  always_comb begin
    en_d     = en_q;
    addr_d   = addr_q;
    int_en_d = int_en_q;
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (apb_wr && reg_sel == R_CTRL)              en_d     = pwdata[0];
    if (apb_wr && reg_sel == R_ADDR)              addr_d   = pwdata[6:0];
    if (apb_wr && reg_sel == R_INT_EN && IRQ_IMPL) int_en_d = pwdata[3:0];

    if (tx_flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wr_q] = pwdata[7:0];
        tx_wr_d           = tx_wr_q + PW'(1);
      end
      if (tx_pop) tx_rd_d = tx_rd_q + PW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end

    if (rx_flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wr_q] = rx_byte;
        rx_wr_d           = rx_wr_q + PW'(1);
      end
      if (rx_pop) rx_rd_d = rx_rd_q + PW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end

    // Set beats W1C in the same cycle; irq is registered off the current flags.
    int_stat_d = IRQ_IMPL ? ((int_stat_q & ~int_clr) | int_set) : 4'h0;
    irq_d      = IRQ_IMPL & (|(int_stat_q & int_en_q));
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en_q       <= 1'b0;
      addr_q     <= DEFAULT_ADDR;
      int_stat_q <= 4'h0;
      int_en_q   <= 4'h0;
      irq_q      <= 1'b0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= 8'h0;
        rx_mem_q[i] <= 8'h0;
      end
    end else begin
      en_q       <= en_d;
      addr_q     <= addr_d;
      int_stat_q <= int_stat_d;
      int_en_q   <= int_en_d;
      irq_q      <= irq_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_mem_q   <= tx_mem_d;
      rx_mem_q   <= rx_mem_d;
    end
  end

  assign pready   = 1'b1;
  assign irq      = irq_q;
  assign core_en  = en_q;
  assign own_addr = addr_q;
  assign tx_byte  = tx_empty ? 8'hFF : tx_mem_q[tx_rd_q];

  assign unused_ok = &{1'b0, paddr[1:0], pwdata[31:8]};
endmodule

// File: tb/tb_i2c_slave_apb_ctrl.sv
// Bench for i2c_slave_apb_ctrl: queue-based reference model, per-cycle compare process, directed and random stimulus.
module tb_i2c_slave_apb_ctrl;
  localparam int DEPTH = 4;
`ifdef I2CS_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [4:0] A_CTRL = 5'h00, A_ADDR = 5'h04, A_STATUS = 5'h08, A_TXDATA = 5'h0C;
  localparam logic [4:0] A_RXDATA = 5'h10, A_INT_STAT = 5'h14, A_INT_EN = 5'h18;

  logic        pclk = 1'b0;
  logic        presetn = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        tx_load = 1'b0, rx_load = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [2:0]  core_state = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, irq, core_en;
  logic [6:0]  own_addr;
  logic [7:0]  tx_byte;

  int n_cmp = 0;
  int n_fail = 0;

  i2c_slave_apb_ctrl #(.FIFO_DEPTH(DEPTH), .DEFAULT_ADDR(7'h50)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .irq(irq), .core_en(core_en), .own_addr(own_addr), .tx_byte(tx_byte),
    .tx_load(tx_load), .rx_byte(rx_byte), .rx_load(rx_load), .core_state(core_state)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFOs as queues, registers as plain variables
  logic [7:0] tx_exp_q[$];
  logic [7:0] exp_q[$];
  logic       m_en;
  logic [6:0] m_addr;
  logic [3:0] m_stat, m_ien;
  logic       m_irq;

  initial forever begin
    @(posedge pclk or negedge presetn);
    if (!presetn) begin
      tx_exp_q.delete();
      exp_q.delete();
      m_en = 1'b0; m_addr = 7'h50; m_stat = 4'h0; m_ien = 4'h0; m_irq = 1'b0;
    end else begin
      automatic logic [2:0] a = paddr[4:2];
      automatic bit wr = psel && penable && pwrite;
      automatic bit rd = psel && penable && !pwrite;
      automatic bit txf = wr && a == 3'd0 && pwdata[2];
      automatic bit rxf = wr && a == 3'd0 && pwdata[1];
      automatic int tsz = tx_exp_q.size();
      automatic int rsz = exp_q.size();
      automatic bit rpop = rd && a == 3'd4 && rsz > 0;
      automatic logic [3:0] set = 4'h0;
      automatic logic [3:0] clr = (wr && a == 3'd5) ? pwdata[3:0] : 4'h0;
      automatic logic nirq = |(m_stat & m_ien);
      if (txf) tx_exp_q.delete();
      else begin
        if (tx_load) begin
          if (tsz > 0) begin void'(tx_exp_q.pop_front()); set[1] = 1'b1; end
          else set[3] = 1'b1;
        end
        if (wr && a == 3'd3 && tsz < DEPTH) tx_exp_q.push_back(pwdata[7:0]);
      end
      if (rxf) exp_q.delete();
      else begin
        if (rpop) void'(exp_q.pop_front());
        if (rx_load) begin
          if (rsz < DEPTH || rpop) begin exp_q.push_back(rx_byte); set[0] = 1'b1; end
          else set[2] = 1'b1;
        end
      end
      if (wr && a == 3'd0) m_en = pwdata[0];
      if (wr && a == 3'd1) m_addr = pwdata[6:0];
      if (IRQ) begin
        m_stat = (m_stat & ~clr) | set;
        if (wr && a == 3'd6) m_ien = pwdata[3:0];
        m_irq = nirq;
      end
    end
  end

  function automatic void exp_read(input logic [2:0] a, output logic [31:0] d, output logic e);
    d = 32'h0;
    e = 1'b0;
    case (a)
      3'd0: d = {31'b0, m_en};
      3'd1: d = {25'b0, m_addr};
      3'd2: begin
        d[0]     = (tx_exp_q.size() == 0);
        d[1]     = (tx_exp_q.size() == DEPTH);
        d[2]     = (exp_q.size() == 0);
        d[3]     = (exp_q.size() == DEPTH);
        d[4]     = (core_state != 3'd0);
        d[7:5]   = core_state;
        d[12:8]  = 5'(tx_exp_q.size());
        d[20:16] = 5'(exp_q.size());
      end
      3'd4: if (exp_q.size() == 0) e = 1'b1; else d = {24'b0, exp_q[0]};
      3'd5: d = {28'b0, m_stat};
      3'd6: d = {28'b0, m_ien};
      default: d = 32'h0;
    endcase
  endfunction

  // scoreboard compare, every cycle away from the active edge
  always @(negedge pclk) begin
    logic [31:0] d;
    logic        e;
    chk("pready", 32'(pready), 32'h1);
    chk("tx_byte", 32'(tx_byte), (tx_exp_q.size() != 0) ? 32'(tx_exp_q[0]) : 32'hFF);
    chk("core_en", 32'(core_en), 32'(m_en));
    chk("own_addr", 32'(own_addr), 32'(m_addr));
    chk("irq", 32'(irq), 32'(m_irq));
    if (!presetn) chk("prdata_rst", prdata, 32'h0);
    else if (psel && penable && !pwrite) begin
      exp_read(paddr[4:2], d, e);
      chk("prdata", prdata, d);
      chk("pslverr_rd", 32'(pslverr), 32'(e));
    end else if (psel && penable) begin
      chk("pslverr_wr", 32'(pslverr), 32'(paddr[4:2] == 3'd3 && tx_exp_q.size() == DEPTH));
    end else begin
      chk("pslverr_idle", 32'(pslverr), 32'h0);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb(input bit wr, input logic [4:0] a, input logic [31:0] wd, input bit txl,
                     input bit rxl, input logic [7:0] rxb, output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    step();
    penable = 1'b1; tx_load = txl; rx_load = rxl; rx_byte = rxb;
    @(negedge pclk);
    rd = prdata;
    err = pslverr;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_load = 1'b0; rx_load = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] wd);
    logic [31:0] d;
    logic e;
    apb(1'b1, a, wd, 1'b0, 1'b0, 8'h0, d, e);
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] d, output logic e);
    apb(1'b0, a, 32'h0, 1'b0, 1'b0, 8'h0, d, e);
  endtask

  task automatic pulse(input bit txl, input bit rxl, input logic [7:0] b);
    tx_load = txl; rx_load = rxl; rx_byte = b;
    step();
    tx_load = 1'b0; rx_load = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [7:0]  b [4];
    int          op, s;
    logic [4:0]  a;

    #1 presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_tx_byte", 32'(tx_byte), 32'hFF);
    chk("rst_core_en", 32'(core_en), 32'h0);
    presetn = 1'b1;
    step();

    // reset register values
    rd_reg(A_CTRL, d, e);     chk("rst_ctrl", d, 32'h0);
    rd_reg(A_ADDR, d, e);     chk("rst_addr", d, 32'h50);
    rd_reg(A_STATUS, d, e);   chk("rst_status", d, 32'h5);
    rd_reg(A_INT_STAT, d, e); chk("rst_int_stat", d, 32'h0);
    rd_reg(A_INT_EN, d, e);   chk("rst_int_en", d, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // TX path
    wr_reg(A_TXDATA, 32'hA1);
    wr_reg(A_TXDATA, 32'hB2);
    chk("tx_head_a1", 32'(tx_byte), 32'hA1);
    rd_reg(A_STATUS, d, e);   chk("tx_status2", d, 32'h0204);
    pulse(1'b1, 1'b0, 8'h0);  chk("tx_head_b2", 32'(tx_byte), 32'hB2);
    pulse(1'b1, 1'b0, 8'h0);  chk("tx_head_ff", 32'(tx_byte), 32'hFF);
    rd_reg(A_STATUS, d, e);   chk("tx_status0", d, 32'h5);
    rd_reg(A_INT_STAT, d, e); chk("tx_req", d, IRQ ? 32'h2 : 32'h0);
    wr_reg(A_INT_STAT, 32'hF);

    // RX fill, overrun, drain, empty read
    wr_reg(A_INT_EN, 32'h1);
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, 8'(8'h11 + i));
    rd_reg(A_STATUS, d, e);   chk("rx_full_status", d, 32'h0004_0009);
    pulse(1'b0, 1'b1, 8'h15);
    rd_reg(A_INT_STAT, d, e); chk("rx_ovr", d, IRQ ? 32'h5 : 32'h0);
    chk("rx_irq", 32'(irq), 32'(IRQ));
    for (int i = 0; i < 4; i++) begin
      rd_reg(A_RXDATA, d, e);
      chk("rx_data", d, 32'(8'h11 + i));
      chk("rx_err", 32'(e), 32'h0);
    end
    rd_reg(A_RXDATA, d, e);
    chk("rx_empty_data", d, 32'h0);
    chk("rx_empty_err", 32'(e), 32'h1);
    chk("rx_irq_hold", 32'(irq), 32'(IRQ));
    wr_reg(A_INT_STAT, 32'h1);
    step();
    chk("rx_irq_clr", 32'(irq), 32'h0);
    rd_reg(A_INT_STAT, d, e); chk("rx_ovr_left", d, IRQ ? 32'h4 : 32'h0);
    wr_reg(A_INT_STAT, 32'hF);

    // TX underrun, irq latency, W1C versus set
    wr_reg(A_INT_EN, 32'h8);
    pulse(1'b1, 1'b0, 8'h0);
    chk("und_irq_1cyc", 32'(irq), 32'h0);
    step();
    chk("und_irq_2cyc", 32'(irq), 32'(IRQ));
    apb(1'b1, A_INT_STAT, 32'h8, 1'b1, 1'b0, 8'h0, d, e);
    rd_reg(A_INT_STAT, d, e); chk("und_set_wins", d, IRQ ? 32'h8 : 32'h0);
    wr_reg(A_INT_STAT, 32'hF);
    wr_reg(A_INT_EN, 32'h0);

    // RX full with same-cycle pop and push
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      pulse(1'b0, 1'b1, b[i]);
    end
    apb(1'b0, A_RXDATA, 32'h0, 1'b0, 1'b1, 8'h77, d, e);
    chk("popush_data", d, 32'(b[0]));
    rd_reg(A_STATUS, d, e);   chk("popush_status", d, 32'h0004_0009);
    rd_reg(A_INT_STAT, d, e); chk("popush_no_ovr", d, IRQ ? 32'h1 : 32'h0);
    for (int i = 1; i < 4; i++) begin
      rd_reg(A_RXDATA, d, e); chk("popush_drain", d, 32'(b[i]));
    end
    rd_reg(A_RXDATA, d, e);   chk("popush_last", d, 32'h77);
    wr_reg(A_INT_STAT, 32'hF);

    // enable, address, flush while busy
    wr_reg(A_CTRL, 32'h1);    chk("en_set", 32'(core_en), 32'h1);
    wr_reg(A_ADDR, 32'h2A);   chk("addr_set", 32'(own_addr), 32'h2A);
    wr_reg(A_TXDATA, 32'h3C);
    pulse(1'b0, 1'b1, 8'h5A);
    core_state = 3'd3;
    wr_reg(A_CTRL, 32'h6);    chk("en_clr", 32'(core_en), 32'h0);
    rd_reg(A_STATUS, d, e);   chk("flush_busy", d, 32'h75);
    core_state = 3'd0;

    // TX overflow and flush colliding with tx_load
    wr_reg(A_INT_STAT, 32'hF);
    for (int i = 0; i < 4; i++) wr_reg(A_TXDATA, 32'(8'hC0 + i));
    apb(1'b1, A_TXDATA, 32'h99, 1'b0, 1'b0, 8'h0, d, e);
    chk("tx_ovf_err", 32'(e), 32'h1);
    rd_reg(A_STATUS, d, e);   chk("tx_full_status", d, 32'h0406);
    apb(1'b1, A_CTRL, 32'h4, 1'b1, 1'b0, 8'h0, d, e);
    chk("flush_tx_byte", 32'(tx_byte), 32'hFF);
    rd_reg(A_INT_STAT, d, e); chk("flush_no_flag", d, 32'h0);

    // random traffic, checked by the compare process
    repeat (400) begin
      op = $urandom_range(0, 3);
      s  = $urandom_range(0, 9);
      core_state = 3'($urandom);
      a = {(s > 7) ? ((op == 3) ? 3'd4 : 3'd3) : 3'(s), 2'($urandom)};
      b[0] = 8'($urandom);
      case (op)
        0, 1: pulse($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, b[0]);
        2: apb(1'b1, a, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, b[0], d, e);
        default: apb(1'b0, a, 32'h0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, b[0], d, e);
      endcase
    end
    core_state = 3'd0;

    // asynchronous reset in the middle of an access
    wr_reg(A_CTRL, 32'h1);
    wr_reg(A_TXDATA, 32'h42);
    psel = 1'b1; pwrite = 1'b1; paddr = A_ADDR; pwdata = 32'h11;
    step();
    penable = 1'b1;
    #3 presetn = 1'b0;
    #1;
    chk("arst_core_en", 32'(core_en), 32'h0);
    chk("arst_tx_byte", 32'(tx_byte), 32'hFF);
    chk("arst_addr", 32'(own_addr), 32'h50);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    step();
    presetn = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
